// File: rtl/olink_rstseq_pkg.sv
// Shared definitions for the optical-link reset sequencer: state encoding,
// default timing and the timer-width helper.
package olink_rstseq_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_QPLL_RST  = 3'd1,
    S_QPLL_WAIT = 3'd2,
    S_MMCM_RST  = 3'd3,
    S_MMCM_WAIT = 3'd4,
    S_GT_RST    = 3'd5,
    S_LINK_WAIT = 3'd6,
    S_RUN       = 3'd7
  } olink_state_e;

  localparam int DEF_NUM_LINKS    = 2;
  localparam int DEF_RST_CYCLES   = 16;
  localparam int DEF_LOCK_TIMEOUT = 125000;
  localparam int DEF_LINK_TIMEOUT = 1250000;
  localparam int DEF_DROP_CYCLES  = 8;

  // Timer only ever counts up to (largest limit - 1), so clog2 of the limit suffices.
  function automatic int cnt_width(input int lock_to, input int link_to, input int rst_cyc);
    int m;
    m = lock_to;
    if (link_to > m) m = link_to;
    if (rst_cyc > m) m = rst_cyc;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/olink_rstseq_debounce.sv
// One-bit consecutive-cycle filter: fire_o is high on the DROP_CYCLES-th
// consecutive cycle that cond_i is high, and stays high while it remains high.
module olink_rstseq_debounce #(
  parameter int DROP_CYCLES = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic cond_i,
  output logic fire_o
);

  localparam int CW = $clog2(DROP_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DROP_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (cond_i) begin
      cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
    end
  end

  assign fire_o = cond_i && (cnt_q == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/olink_reset_seq.sv
// QPLL -> MMCM -> GTX reset sequencer with lock/link timeouts and RUN loss recovery.
// Define OLINK_RSTSEQ_DEBOUNCE_EN to require DROP_CYCLES of persistent loss in RUN.
module olink_reset_seq
  import olink_rstseq_pkg::*;
#(
  parameter int NUM_LINKS    = DEF_NUM_LINKS,
  parameter int RST_CYCLES   = DEF_RST_CYCLES,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LINK_TIMEOUT = DEF_LINK_TIMEOUT,
  parameter int DROP_CYCLES  = DEF_DROP_CYCLES
) (
  input  logic                 sysClk125,
  input  logic                 sysClk125RstN,
  input  logic                 enable,
  input  logic                 force_reset,
  input  logic [NUM_LINKS-1:0] link_mask,
  input  logic                 qpll_lock,
  input  logic                 qpll_refclklost,
  input  logic                 mmcm_locked,
  input  logic [NUM_LINKS-1:0] link_valid,
  output logic                 qpll_reset,
  output logic                 mmcm_reset,
  output logic [NUM_LINKS-1:0] gt_reset,
  output logic [2:0]           state,
  output logic [NUM_LINKS-1:0] links_up,
  output logic                 all_up,
  output logic [7:0]           retry_count,
  output logic                 timeout_err
);

  localparam int TW = cnt_width(LOCK_TIMEOUT, LINK_TIMEOUT, RST_CYCLES);
  localparam logic [TW-1:0] RST_LAST  = TW'(RST_CYCLES - 1);
  localparam logic [TW-1:0] LOCK_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] LINK_LAST = TW'(LINK_TIMEOUT - 1);

  olink_state_e         state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [7:0]           retry_q, retry_d;
  logic                 err_q, err_d;
  logic                 qpll_reset_q, qpll_reset_d;
  logic                 mmcm_reset_q, mmcm_reset_d;
  logic [NUM_LINKS-1:0] gt_reset_q, gt_reset_d;
  logic [NUM_LINKS-1:0] links_up_q, links_up_d;
  logic                 all_up_q, all_up_d;

  logic qpll_ok, links_ok, in_run;
  logic qpll_loss, mmcm_loss, link_loss;
  logic qpll_drop, mmcm_drop, link_drop;
  logic timeout, bump, restart;

  assign qpll_ok   = qpll_lock && !qpll_refclklost;
  assign links_ok  = ((link_valid & link_mask) == link_mask);
  assign in_run    = (state_q == S_RUN);
  assign qpll_loss = in_run && !qpll_ok;
  assign mmcm_loss = in_run && !mmcm_locked;
  assign link_loss = in_run && |(~link_valid & link_mask);

`ifdef OLINK_RSTSEQ_DEBOUNCE_EN
  // Loss inputs are gated with RUN so each filter starts clean on every entry.
  olink_rstseq_debounce #(.DROP_CYCLES(DROP_CYCLES)) u_db_qpll (
    .clk(sysClk125), .rst_n(sysClk125RstN), .cond_i(qpll_loss), .fire_o(qpll_drop)
  );
  olink_rstseq_debounce #(.DROP_CYCLES(DROP_CYCLES)) u_db_mmcm (
    .clk(sysClk125), .rst_n(sysClk125RstN), .cond_i(mmcm_loss), .fire_o(mmcm_drop)
  );
  olink_rstseq_debounce #(.DROP_CYCLES(DROP_CYCLES)) u_db_link (
    .clk(sysClk125), .rst_n(sysClk125RstN), .cond_i(link_loss), .fire_o(link_drop)
  );
`else
  logic [31:0] drop_cycles_unused;
  assign drop_cycles_unused = DROP_CYCLES;
  assign qpll_drop = qpll_loss;
  assign mmcm_drop = mmcm_loss;
  assign link_drop = link_loss;
`endif

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    err_d   = err_q;
    timeout = 1'b0;
    bump    = 1'b0;
    restart = 1'b0;

    if (!enable) begin
      state_d = S_IDLE;
      if (force_reset) begin
        retry_d = '0;
        err_d   = 1'b0;
      end
    end else if (force_reset) begin
      state_d = S_QPLL_RST;
      retry_d = '0;
      err_d   = 1'b0;
      restart = 1'b1;
    end else begin
      case (state_q)
        S_IDLE:      state_d = S_QPLL_RST;
        S_QPLL_RST:  if (timer_q == RST_LAST) state_d = S_QPLL_WAIT;
        S_QPLL_WAIT: begin
          if (qpll_ok) state_d = S_MMCM_RST;
          else if (timer_q == LOCK_LAST) timeout = 1'b1;
        end
        S_MMCM_RST:  if (timer_q == RST_LAST) state_d = S_MMCM_WAIT;
        S_MMCM_WAIT: begin
          if (mmcm_locked) state_d = S_GT_RST;
          else if (timer_q == LOCK_LAST) timeout = 1'b1;
        end
        S_GT_RST:    if (timer_q == RST_LAST) state_d = S_LINK_WAIT;
        S_LINK_WAIT: begin
          if (links_ok) state_d = S_RUN;
          else if (timer_q == LINK_LAST) timeout = 1'b1;
        end
        S_RUN: begin
          // Restart only the deepest stage that was lost.
          if (qpll_drop) begin
            state_d = S_QPLL_RST;
            bump    = 1'b1;
          end else if (mmcm_drop) begin
            state_d = S_MMCM_RST;
            bump    = 1'b1;
          end else if (link_drop) begin
            state_d = S_GT_RST;
            bump    = 1'b1;
          end
        end
        default:     state_d = S_IDLE;
      endcase

      if (timeout) begin
        state_d = S_QPLL_RST;
        err_d   = 1'b1;
        bump    = 1'b1;
      end
      if (bump && retry_q != 8'hFF) begin
        retry_d = retry_q + 8'd1;
      end
    end

    if (state_d != state_q || restart || state_q == S_IDLE || state_q == S_RUN) begin
      timer_d = '0;
    end else begin
      timer_d = timer_q + TW'(1);
    end

    qpll_reset_d = (state_d == S_IDLE) || (state_d == S_QPLL_RST);
    mmcm_reset_d = qpll_reset_d || (state_d == S_QPLL_WAIT) || (state_d == S_MMCM_RST);
    gt_reset_d   = {NUM_LINKS{(state_d != S_LINK_WAIT) && (state_d != S_RUN)}};
    links_up_d   = link_valid & link_mask;
    all_up_d     = (state_d == S_RUN);
  end

  always_ff @(posedge sysClk125) begin
    if (!sysClk125RstN) begin
      state_q      <= S_IDLE;
      timer_q      <= '0;
      retry_q      <= '0;
      err_q        <= 1'b0;
      qpll_reset_q <= 1'b1;
      mmcm_reset_q <= 1'b1;
      gt_reset_q   <= '1;
      links_up_q   <= '0;
      all_up_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      timer_q      <= timer_d;
      retry_q      <= retry_d;
      err_q        <= err_d;
      qpll_reset_q <= qpll_reset_d;
      mmcm_reset_q <= mmcm_reset_d;
      gt_reset_q   <= gt_reset_d;
      links_up_q   <= links_up_d;
      all_up_q     <= all_up_d;
    end
  end

  assign state       = state_q;
  assign qpll_reset  = qpll_reset_q;
  assign mmcm_reset  = mmcm_reset_q;
  assign gt_reset    = gt_reset_q;
  assign links_up    = links_up_q;
  assign all_up      = all_up_q;
  assign retry_count = retry_q;
  assign timeout_err = err_q;

endmodule

// File: tb/tb_olink_reset_seq.sv
// Directed self-checking bench for olink_reset_seq (RST=4, LOCK=20, LINK=40 cycles).
module tb_olink_reset_seq;

`ifdef OLINK_RSTSEQ_DEBOUNCE_EN
  localparam int LOSS_TICKS = 8;
`else
  localparam int LOSS_TICKS = 1;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       force_reset = 1'b0;
  logic [1:0] link_mask = 2'b11;
  logic       qpll_lock = 1'b0;
  logic       qpll_refclklost = 1'b0;
  logic       mmcm_locked = 1'b0;
  logic [1:0] link_valid = 2'b00;
  logic       qpll_reset, mmcm_reset, all_up, timeout_err;
  logic [1:0] gt_reset, links_up;
  logic [2:0] state;
  logic [7:0] retry_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  olink_reset_seq #(
    .NUM_LINKS(2), .RST_CYCLES(4), .LOCK_TIMEOUT(20), .LINK_TIMEOUT(40), .DROP_CYCLES(8)
  ) dut (
    .sysClk125(clk), .sysClk125RstN(rst_n), .enable(enable), .force_reset(force_reset),
    .link_mask(link_mask), .qpll_lock(qpll_lock), .qpll_refclklost(qpll_refclklost),
    .mmcm_locked(mmcm_locked), .link_valid(link_valid), .qpll_reset(qpll_reset),
    .mmcm_reset(mmcm_reset), .gt_reset(gt_reset), .state(state), .links_up(links_up),
    .all_up(all_up), .retry_count(retry_count), .timeout_err(timeout_err)
  );

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; enable = 1'b0; force_reset = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic wait_state(input logic [2:0] target);
    int n;
    n = 0;
    while (state !== target && n < 200) begin
      tick(1);
      n++;
    end
    checks++;
    if (state !== target) begin
      errors++;
      $display("FAIL wait_state got %0d required %0d (timed out)", state, target);
    end
  endtask

  task automatic bring_up();
    enable = 1'b1;
    wait_state(3'd7);
  endtask

  task automatic test_reset();
    do_reset();
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({state, qpll_reset, mmcm_reset, gt_reset} !== {3'd0, 1'b1, 1'b1, 2'b11}) begin
      errors++;
      $display("FAIL reset_resets got st=%0d q=%b m=%b gt=%b required 0 1 1 11",
               state, qpll_reset, mmcm_reset, gt_reset);
    end
    checks++;
    if ({links_up, all_up, retry_count, timeout_err} !== 12'd0) begin
      errors++;
      $display("FAIL reset_status got up=%b all=%b retry=%0d err=%b required 0",
               links_up, all_up, retry_count, timeout_err);
    end
    rst_n = 1'b1;
    $display("test_reset done");
  endtask

  task automatic test_nominal();
    do_reset();
    link_mask = 2'b11; qpll_lock = 1'b0; mmcm_locked = 1'b0; link_valid = 2'b00;
    enable = 1'b1;
    tick(1);
    checks++;
    if ({state, qpll_reset} !== {3'd1, 1'b1}) begin
      errors++;
      $display("FAIL nom_enter_qpll_rst got st=%0d q=%b required 1 1", state, qpll_reset);
    end
    tick(3);
    checks++;
    if ({state, qpll_reset} !== {3'd1, 1'b1}) begin
      errors++;
      $display("FAIL nom_qpll_rst_hold got st=%0d q=%b required 1 1", state, qpll_reset);
    end
    tick(1);
    checks++;
    if ({state, qpll_reset, mmcm_reset, gt_reset} !== {3'd2, 1'b0, 1'b1, 2'b11}) begin
      errors++;
      $display("FAIL nom_qpll_wait got st=%0d q=%b m=%b gt=%b required 2 0 1 11",
               state, qpll_reset, mmcm_reset, gt_reset);
    end
    qpll_lock = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd3) begin
      errors++;
      $display("FAIL nom_mmcm_rst got %0d required 3", state);
    end
    tick(4);
    checks++;
    if ({state, mmcm_reset, gt_reset} !== {3'd4, 1'b0, 2'b11}) begin
      errors++;
      $display("FAIL nom_mmcm_wait got st=%0d m=%b gt=%b required 4 0 11", state, mmcm_reset, gt_reset);
    end
    mmcm_locked = 1'b1;
    tick(1);
    checks++;
    if (state !== 3'd5) begin
      errors++;
      $display("FAIL nom_gt_rst got %0d required 5", state);
    end
    tick(4);
    checks++;
    if ({state, gt_reset} !== {3'd6, 2'b00}) begin
      errors++;
      $display("FAIL nom_link_wait got st=%0d gt=%b required 6 00", state, gt_reset);
    end
    link_valid = 2'b11;
    tick(1);
    checks++;
    if ({state, all_up, links_up, retry_count} !== {3'd7, 1'b1, 2'b11, 8'd0}) begin
      errors++;
      $display("FAIL nom_run got st=%0d all=%b up=%b retry=%0d required 7 1 11 0",
               state, all_up, links_up, retry_count);
    end
    $display("test_nominal done");
  endtask

  task automatic test_qpll_timeout();
    do_reset();
    qpll_lock = 1'b0; mmcm_locked = 1'b0; link_valid = 2'b00;
    enable = 1'b1;
    wait_state(3'd2);
    tick(19);
    checks++;
    if ({state, timeout_err} !== {3'd2, 1'b0}) begin
      errors++;
      $display("FAIL to_before_limit got st=%0d err=%b required 2 0", state, timeout_err);
    end
    tick(1);
    checks++;
    if ({state, timeout_err, retry_count} !== {3'd1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL to_expired got st=%0d err=%b retry=%0d required 1 1 1", state, timeout_err, retry_count);
    end
    wait_state(3'd2);
    tick(19);
    qpll_lock = 1'b1;
    tick(1);
    checks++;
    if ({state, retry_count, timeout_err} !== {3'd3, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL to_coincident_lock got st=%0d retry=%0d err=%b required 3 1 1",
               state, retry_count, timeout_err);
    end
    $display("test_qpll_timeout done");
  endtask

  task automatic test_run_priority();
    do_reset();
    link_mask = 2'b11; qpll_lock = 1'b1; mmcm_locked = 1'b1; link_valid = 2'b11;
    bring_up();
    qpll_lock = 1'b0; link_valid = 2'b01;
    tick(LOSS_TICKS);
    checks++;
    if ({state, qpll_reset, mmcm_reset, gt_reset, all_up} !== {3'd1, 1'b1, 1'b1, 2'b11, 1'b0}) begin
      errors++;
      $display("FAIL prio_qpll got st=%0d q=%b m=%b gt=%b all=%b required 1 1 1 11 0",
               state, qpll_reset, mmcm_reset, gt_reset, all_up);
    end
    checks++;
    if (retry_count !== 8'd1) begin
      errors++;
      $display("FAIL prio_retry got %0d required 1", retry_count);
    end
    $display("test_run_priority done");
  endtask

  task automatic test_partial_mask();
    do_reset();
    link_mask = 2'b01; qpll_lock = 1'b1; mmcm_locked = 1'b1; link_valid = 2'b01;
    bring_up();
    link_valid = 2'b11;
    tick(1);
    link_valid = 2'b01;
    tick(LOSS_TICKS + 2);
    checks++;
    if ({state, links_up, retry_count} !== {3'd7, 2'b01, 8'd0}) begin
      errors++;
      $display("FAIL mask_ignore got st=%0d up=%b retry=%0d required 7 01 0", state, links_up, retry_count);
    end
    link_valid = 2'b00;
    tick(LOSS_TICKS);
    checks++;
    if ({state, qpll_reset, mmcm_reset, gt_reset, retry_count} !== {3'd5, 1'b0, 1'b0, 2'b11, 8'd1}) begin
      errors++;
      $display("FAIL mask_link0 got st=%0d q=%b m=%b gt=%b retry=%0d required 5 0 0 11 1",
               state, qpll_reset, mmcm_reset, gt_reset, retry_count);
    end
    link_mask = 2'b11;
    $display("test_partial_mask done");
  endtask

  task automatic test_control();
    do_reset();
    qpll_lock = 1'b0; mmcm_locked = 1'b0; link_valid = 2'b00;
    enable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_state(3'd2);
      tick(20);
    end
    checks++;
    if ({retry_count, timeout_err} !== {8'd5, 1'b1}) begin
      errors++;
      $display("FAIL ctl_retry5 got retry=%0d err=%b required 5 1", retry_count, timeout_err);
    end
    force_reset = 1'b1;
    tick(1);
    force_reset = 1'b0;
    checks++;
    if ({state, retry_count, timeout_err} !== {3'd1, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL ctl_force got st=%0d retry=%0d err=%b required 1 0 0", state, retry_count, timeout_err);
    end
    qpll_lock = 1'b1;
    wait_state(3'd4);
    tick(3);
    enable = 1'b0;
    tick(1);
    checks++;
    if ({state, qpll_reset, mmcm_reset, gt_reset} !== {3'd0, 1'b1, 1'b1, 2'b11}) begin
      errors++;
      $display("FAIL ctl_disable got st=%0d q=%b m=%b gt=%b required 0 1 1 11",
               state, qpll_reset, mmcm_reset, gt_reset);
    end
    enable = 1'b1; mmcm_locked = 1'b1;
    wait_state(3'd6);
    tick(39);
    checks++;
    if (state !== 3'd6) begin
      errors++;
      $display("FAIL ctl_link_wait_hold got %0d required 6", state);
    end
    tick(1);
    checks++;
    if ({state, timeout_err, retry_count} !== {3'd1, 1'b1, 8'd1}) begin
      errors++;
      $display("FAIL ctl_link_timeout got st=%0d err=%b retry=%0d required 1 1 1",
               state, timeout_err, retry_count);
    end
    enable = 1'b0;
    tick(1);
    checks++;
    if ({state, retry_count, timeout_err} !== {3'd0, 8'd1, 1'b1}) begin
      errors++;
      $display("FAIL ctl_retain got st=%0d retry=%0d err=%b required 0 1 1", state, retry_count, timeout_err);
    end
    force_reset = 1'b1;
    tick(1);
    force_reset = 1'b0;
    checks++;
    if ({state, retry_count, timeout_err} !== {3'd0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL ctl_force_disabled got st=%0d retry=%0d err=%b required 0 0 0",
               state, retry_count, timeout_err);
    end
    enable = 1'b1;
    wait_state(3'd6);
    tick(5);
    rst_n = 1'b0;
    tick(1);
    checks++;
    if ({state, qpll_reset, mmcm_reset, gt_reset, links_up, all_up, retry_count, timeout_err}
        !== {3'd0, 1'b1, 1'b1, 2'b11, 2'b00, 1'b0, 8'd0, 1'b0}) begin
      errors++;
      $display("FAIL ctl_reset_mid got st=%0d q=%b m=%b gt=%b up=%b all=%b retry=%0d err=%b",
               state, qpll_reset, mmcm_reset, gt_reset, links_up, all_up, retry_count, timeout_err);
    end
    rst_n = 1'b1;
    $display("test_control done");
  endtask

  task automatic test_mmcm_loss();
    do_reset();
    link_mask = 2'b11; qpll_lock = 1'b1; mmcm_locked = 1'b1; link_valid = 2'b11;
    bring_up();
`ifdef OLINK_RSTSEQ_DEBOUNCE_EN
    mmcm_locked = 1'b0;
    tick(7);
    mmcm_locked = 1'b1;
    tick(3);
    checks++;
    if ({state, retry_count} !== {3'd7, 8'd0}) begin
      errors++;
      $display("FAIL mmcm_glitch7 got st=%0d retry=%0d required 7 0", state, retry_count);
    end
`endif
    mmcm_locked = 1'b0;
    tick(LOSS_TICKS);
    checks++;
    if ({state, qpll_reset, mmcm_reset, gt_reset, retry_count} !== {3'd3, 1'b0, 1'b1, 2'b11, 8'd1}) begin
      errors++;
      $display("FAIL mmcm_loss got st=%0d q=%b m=%b gt=%b retry=%0d required 3 0 1 11 1",
               state, qpll_reset, mmcm_reset, gt_reset, retry_count);
    end
    $display("test_mmcm_loss done");
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_qpll_timeout();
    test_run_priority();
    test_partial_mask();
    test_control();
    test_mmcm_loss();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
